// File: rtl/sobel_frame_io.sv
// Sobel front end: four-slot line store feeding a 3-row window column per pixel,
// plus an 8N1 UART serialiser for result bytes toward the host.
module sobel_frame_io #(
  parameter int AW       = 7,
  parameter int DW       = 8,
  parameter int BAUD_DIV = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_stb,
  input  logic          href,
  input  logic          vsync,
  input  logic [DW-1:0] pix_in,
  output logic [DW-1:0] win_top,
  output logic [DW-1:0] win_mid,
  output logic [DW-1:0] win_bot,
  output logic          win_valid,
  input  logic          res_stb,
  input  logic [DW-1:0] res_data,
  output logic          tx,
  output logic          tx_busy
);

  localparam int LINE_W = 3 * (2 ** AW);
  localparam int CW     = AW + 2;
  localparam int IW     = AW + 4;
  localparam int CNTW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BW     = (DW > 1) ? $clog2(DW) : 1;

  // Slot s, column c lives at s*LINE_W + c; bank = c>>AW, address = c[AW-1:0].
  logic [DW-1:0] line_ram [4*LINE_W];

  logic [CW-1:0] col_q, col_d;
  logic [1:0]    w_q, w_d;
  logic [1:0]    lines_q, lines_d;
  logic          href_q, href_d;
  logic [DW-1:0] win_top_q, win_top_d;
  logic [DW-1:0] win_mid_q, win_mid_d;
  logic [DW-1:0] win_bot_q, win_bot_d;
  logic          win_valid_q, win_valid_d;

  logic accept, in_range, eol, wr_en, rd_en;

  function automatic logic [IW-1:0] ram_idx(input logic [1:0] slot, input logic [CW-1:0] c);
    return IW'(slot) * IW'(LINE_W) + IW'(c);
  endfunction

  assign accept   = pix_stb & href & ~vsync;
  assign in_range = (col_q < CW'(LINE_W));
  assign eol      = href_q & ~href;
  assign wr_en    = accept & in_range;
  assign rd_en    = wr_en & (lines_q == 2'd3);

  always_comb begin
    href_d  = href;
    col_d   = col_q;
    w_d     = w_q;
    lines_d = lines_q;
    if (vsync) begin
      col_d   = '0;
      w_d     = '0;
      lines_d = '0;
    end else if (eol) begin
      // An href pulse that carried no pixels leaves the ring untouched.
      if (col_q != '0) begin
        w_d     = w_q + 2'd1;
        lines_d = (lines_q == 2'd3) ? 2'd3 : lines_q + 2'd1;
        col_d   = '0;
      end
    end else if (wr_en) begin
      col_d = col_q + CW'(1);
    end
  end

  always_comb begin
    win_valid_d = rd_en;
    win_top_d   = win_top_q;
    win_mid_d   = win_mid_q;
    win_bot_d   = win_bot_q;
    if (rd_en) begin
      win_top_d = line_ram[ram_idx(w_q + 2'd1, col_q)];
      win_mid_d = line_ram[ram_idx(w_q + 2'd2, col_q)];
      win_bot_d = line_ram[ram_idx(w_q + 2'd3, col_q)];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      line_ram[ram_idx(w_q, col_q)] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      w_q         <= '0;
      lines_q     <= '0;
      href_q      <= 1'b0;
      win_top_q   <= '0;
      win_mid_q   <= '0;
      win_bot_q   <= '0;
      win_valid_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      w_q         <= w_d;
      lines_q     <= lines_d;
      href_q      <= href_d;
      win_top_q   <= win_top_d;
      win_mid_q   <= win_mid_d;
      win_bot_q   <= win_bot_d;
      win_valid_q <= win_valid_d;
    end
  end

  assign win_top   = win_top_q;
  assign win_mid   = win_mid_q;
  assign win_bot   = win_bot_q;
  assign win_valid = win_valid_q;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  uart_state_e   state_q, state_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic          baud_tick;

  assign baud_tick = (cnt_q == CNTW'(BAUD_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    cnt_d   = baud_tick ? '0 : cnt_q + CNTW'(1);
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (res_stb) begin
          state_d = S_START;
          shift_d = res_data;
          bit_d   = '0;
        end
      end
      S_START: if (baud_tick) state_d = S_DATA;
      S_DATA: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + BW'(1);
          if (bit_q == BW'(DW - 1)) state_d = S_STOP;
        end
      end
      default: if (baud_tick) state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_busy = (state_q != S_IDLE);
    case (state_q)
      S_START: tx = 1'b0;
      S_DATA:  tx = shift_q[0];
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_sobel_frame_io.sv
// Bench for sobel_frame_io: line-history reference model for the window, bit-frame model for the UART.
module tb_sobel_frame_io;

  localparam int AW = 7;
  localparam int DW = 8;
  localparam int BAUD_DIV = 1;
  localparam int LINE_W = 384;

  logic       clk = 1'b0;
  logic       rst, pix_stb, href, vsync, res_stb;
  logic [7:0] pix_in, res_data;
  logic [7:0] win_top, win_mid, win_bot;
  logic       win_valid, tx, tx_busy;

  always #5 clk = ~clk;

  sobel_frame_io #(.AW(AW), .DW(DW), .BAUD_DIV(BAUD_DIV)) dut (
    .clk(clk), .rst(rst), .pix_stb(pix_stb), .href(href), .vsync(vsync), .pix_in(pix_in),
    .win_top(win_top), .win_mid(win_mid), .win_bot(win_bot), .win_valid(win_valid),
    .res_stb(res_stb), .res_data(res_data), .tx(tx), .tx_busy(tx_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int vcount   = 0;

  // Reference: current line plus the three most recent completed lines (0 = oldest).
  logic [7:0] m_cur [LINE_W];
  bit         m_cur_ok [LINE_W];
  logic [7:0] m_hist [3][LINE_W];
  bit         m_hist_ok [3][LINE_W];
  int         m_col;
  int         m_lines;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_col = 0;
    m_lines = 0;
    for (int i = 0; i < LINE_W; i++) begin
      m_cur_ok[i] = 0;
      for (int j = 0; j < 3; j++) m_hist_ok[j][i] = 0;
    end
  endtask

  task automatic check_idle(input string tag);
    n_checks++;
    if (win_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: win_valid=%b expected 0", tag, win_valid);
    end
  endtask

  task automatic drive_pix(input logic [7:0] v, input string tag);
    bit exp_v;
    int c;
    c = m_col;
    exp_v = (m_lines >= 3) && (c < LINE_W);
    pix_stb = 1'b1;
    href = 1'b1;
    pix_in = v;
    tick();
    pix_stb = 1'b0;
    pix_in = 8'($urandom);
    n_checks++;
    if (win_valid !== exp_v) begin
      n_fail++;
      $display("FAIL %s col %0d: win_valid=%b expected %b", tag, c, win_valid, exp_v);
    end
    if (win_valid === 1'b1) vcount++;
    if (exp_v) begin
      if (m_hist_ok[0][c]) begin
        n_checks++;
        if (win_top !== m_hist[0][c]) begin
          n_fail++;
          $display("FAIL %s col %0d: win_top=%h expected %h", tag, c, win_top, m_hist[0][c]);
        end
      end
      if (m_hist_ok[1][c]) begin
        n_checks++;
        if (win_mid !== m_hist[1][c]) begin
          n_fail++;
          $display("FAIL %s col %0d: win_mid=%h expected %h", tag, c, win_mid, m_hist[1][c]);
        end
      end
      if (m_hist_ok[2][c]) begin
        n_checks++;
        if (win_bot !== m_hist[2][c]) begin
          n_fail++;
          $display("FAIL %s col %0d: win_bot=%h expected %h", tag, c, win_bot, m_hist[2][c]);
        end
      end
    end
    if (c < LINE_W) begin
      m_cur[c] = v;
      m_cur_ok[c] = 1;
    end
    m_col++;
  endtask

  task automatic end_line(input string tag);
    href = 1'b0;
    tick();
    check_idle(tag);
    if (m_col > 0) begin
      for (int i = 0; i < LINE_W; i++) begin
        m_hist[0][i] = m_hist[1][i];  m_hist_ok[0][i] = m_hist_ok[1][i];
        m_hist[1][i] = m_hist[2][i];  m_hist_ok[1][i] = m_hist_ok[2][i];
        m_hist[2][i] = m_cur[i];      m_hist_ok[2][i] = m_cur_ok[i];
        m_cur_ok[i] = 0;
      end
      if (m_lines < 3) m_lines++;
    end
    m_col = 0;
    tick();
    check_idle(tag);
  endtask

  // mode 0: pixel = line_no*16 + col%16, mode 1: random bytes.
  task automatic send_line(input int n, input int mode, input int gap_pct, input int line_no, input string tag);
    logic [7:0] v;
    href = 1'b1;
    tick();
    check_idle(tag);
    for (int c = 0; c < n; c++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        tick();
        check_idle(tag);
      end
      v = (mode == 0) ? 8'(line_no * 16 + (c % 16)) : 8'($urandom);
      drive_pix(v, tag);
    end
    end_line(tag);
  endtask

  task automatic do_vsync(input string tag);
    vsync = 1'b1;
    tick();
    check_idle(tag);
    href = 1'b1;
    pix_stb = 1'b1;
    pix_in = 8'($urandom);
    tick();
    pix_stb = 1'b0;
    check_idle(tag);
    href = 1'b0;
    tick();
    check_idle(tag);
    vsync = 1'b0;
    model_clear();
    tick();
    check_idle(tag);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: tx=%b expected 1", tx); end
    n_checks++;
    if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: tx_busy=%b expected 0", tx_busy); end
    n_checks++;
    if (win_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: win_valid=%b expected 0", win_valid); end
    n_checks++;
    if ({win_top, win_mid, win_bot} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_win: win=%h %h %h expected 00 00 00", win_top, win_mid, win_bot);
    end
    rst = 1'b0;
    model_clear();
    tick();
  endtask

  task automatic test_window();
    for (int l = 0; l < 3; l++) send_line(320, 0, 0, l, "fill");
    vcount = 0;
    send_line(320, 0, 0, 3, "window");
    n_checks++;
    if (vcount !== 320) begin n_fail++; $display("FAIL window_count: pulses=%0d expected 320", vcount); end
  endtask

  task automatic test_roll();
    vcount = 0;
    send_line(320, 0, 0, 4, "roll");
    n_checks++;
    if (vcount !== 320) begin n_fail++; $display("FAIL roll_count: pulses=%0d expected 320", vcount); end
  endtask

  task automatic test_vsync();
    int n;
    do_vsync("vsync1");
    send_line(300, 1, 10, 0, "vs_a");
    send_line(300, 1, 10, 0, "vs_b");
    do_vsync("vsync2");
    send_line(384, 1, 15, 0, "vs_c");
    href = 1'b1;
    tick();
    check_idle("empty_href");
    tick();
    check_idle("empty_href");
    end_line("empty_href");
    send_line(384, 1, 15, 0, "vs_d");
    send_line(384, 1, 15, 0, "vs_e");
    n = $urandom_range(384, 100);
    vcount = 0;
    send_line(n, 1, 20, 0, "vs_f");
    n_checks++;
    if (vcount !== n) begin n_fail++; $display("FAIL vsync_count: pulses=%0d expected %0d", vcount, n); end
  endtask

  task automatic test_overflow();
    vcount = 0;
    send_line(400, 1, 0, 0, "ovf");
    n_checks++;
    if (vcount !== 384) begin n_fail++; $display("FAIL ovf_count: pulses=%0d expected 384", vcount); end
    send_line(384, 1, 0, 0, "ovf_next");
  endtask

  task automatic test_back_to_back();
    for (int l = 0; l < 6; l++) begin
      send_line($urandom_range(384, 1), 1, ($urandom_range(1) == 1) ? 30 : 0, 0, "b2b");
      pix_stb = 1'b1;
      pix_in = 8'($urandom);
      tick();
      pix_stb = 1'b0;
      check_idle("stray_stb");
    end
  endtask

  task automatic test_reset_midframe();
    href = 1'b1;
    for (int c = 0; c < 50; c++) drive_pix(8'($urandom), "pre_rst");
    rst = 1'b1;
    href = 1'b0;
    tick();
    rst = 1'b0;
    model_clear();
    n_checks++;
    if (win_valid !== 1'b0 || {win_top, win_mid, win_bot} !== 24'h0) begin
      n_fail++;
      $display("FAIL midrst_win: valid=%b win=%h %h %h expected 0 00 00 00", win_valid, win_top, win_mid, win_bot);
    end
    for (int l = 0; l < 3; l++) send_line(256, 1, 5, 0, "post_rst");
    vcount = 0;
    send_line(256, 1, 5, 0, "post_rst4");
    n_checks++;
    if (vcount !== 256) begin n_fail++; $display("FAIL midrst_count: pulses=%0d expected 256", vcount); end
  endtask

  task automatic uart_frame(input logic [7:0] d, input bit drop_at5, input string tag);
    logic exp_bit;
    res_stb = 1'b1;
    res_data = d;
    tick();
    res_stb = 1'b0;
    res_data = 8'($urandom);
    for (int k = 0; k < 10; k++) begin
      exp_bit = (k == 0) ? 1'b0 : (k <= 8) ? d[k-1] : 1'b1;
      n_checks++;
      if (tx !== exp_bit || tx_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s bit %0d: tx=%b busy=%b expected tx=%b busy=1", tag, k, tx, tx_busy, exp_bit);
      end
      res_stb = (drop_at5 && k == 4);
      res_data = ~d;
      tick();
    end
    res_stb = 1'b0;
    n_checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s end: tx=%b busy=%b expected tx=1 busy=0", tag, tx, tx_busy);
    end
  endtask

  task automatic test_uart();
    uart_frame(8'hA5, 1'b1, "uart_a5");
    uart_frame(8'($urandom), 1'b0, "uart_b2b");
    for (int i = 0; i < 6; i++) begin
      for (int g = 0; g < int'($urandom_range(3)); g++) tick();
      uart_frame(8'($urandom), ($urandom_range(1) == 1), "uart_rand");
    end
  endtask

  task automatic test_uart_abort();
    res_stb = 1'b1;
    res_data = 8'h00;
    tick();
    res_stb = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    n_checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL uart_abort: tx=%b busy=%b expected tx=1 busy=0", tx, tx_busy);
    end
    uart_frame(8'h3C, 1'b0, "uart_after_abort");
  endtask

  initial begin
    rst = 1'b1;
    pix_stb = 1'b0;
    href = 1'b0;
    vsync = 1'b0;
    pix_in = 8'h00;
    res_stb = 1'b0;
    res_data = 8'h00;
    model_clear();
    test_reset();
    test_window();
    test_roll();
    test_vsync();
    test_overflow();
    test_back_to_back();
    test_reset_midframe();
    test_uart();
    test_uart_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_frame_io.md
# sobel_frame_io

Pixel-side front end and serial back end of the Sobel edge-detection pipeline. It captures camera luminance bytes into a four-line ring of block RAMs and presents, for every new pixel, the matching column of the three most recent complete lines. That column is the 3-row window source for the Sobel kernel. It also serialises each Sobel result byte onto a UART line (8N1) toward the host PC.

## Interface
Parameters:
- AW, 7: address width of each RAM bank (2^AW bytes per bank).
- DW, 8: pixel/data width.
- BAUD_DIV, 1: clk cycles per UART bit (1 = 12 Mbaud at 12 MHz).

Ports:
- clk  in  1  system clock; reset rst, synchronous, active-high; clock clk.
- rst  in  1  synchronous active-high reset.
- pix_stb  in  1  one-cycle strobe per luminance pixel.
- href  in  1  line-active qualifier.
- vsync  in  1  frame sync; high = vertical blanking.
- pix_in  in  DW  luminance byte, valid with pix_stb.
- win_top / win_mid / win_bot  out  DW each  column c of lines n-3 / n-2 / n-1.
- win_valid  out  1  one-cycle pulse; window outputs valid.
- res_stb  in  1  one-cycle strobe; res_data to transmit.
- res_data  in  DW  result byte.
- tx  out  1  UART line, idle high.
- tx_busy  out  1  high while a frame is on the line.

## Operation
- Storage: 4 line slots × 3 banks × 2^AW bytes, i.e. 12 banks with synchronous 1-cycle read. Column c maps to bank c>>AW and address c[AW-1:0]. Capacity is 384 columns per line.
- Accepted pixel: pix_stb & href & !vsync in the same cycle. Each accepted pixel is written to slot w at column col, and col increments.
- Columns ≥ 3·2^AW: the write is ignored and col saturates. No wrap.
- End of line (href falling edge, detected with registered href):
  - If col > 0: w ← (w+1) mod 4, lines ← min(lines+1, 3), col ← 0.
  - If col = 0: nothing changes.
- vsync high: col, w and lines are held at 0. No writes occur.
- Read: every accepted pixel also reads column col from slots (w-3), (w-2), (w-1) mod 4, mapped to win_top, win_mid, win_bot respectively.
- win_valid pulses only when lines = 3. Window outputs hold their last value otherwise.
- Writing slot w never aliases the three read slots.
- UART, when idle and res_stb is seen:
  - Latch res_data and assert tx_busy.
  - Send start bit 0, data bits 0..7 LSB first, then stop bit 1. Each bit lasts BAUD_DIV cycles.
- res_stb while tx_busy: the byte is dropped. No queue.
- vsync does not abort a frame already in flight.

## Timing
- Reset values:
  - tx = 1, tx_busy = 0, win_valid = 0.
  - win_* = 0.
  - col = 0, w = 0, lines = 0.
  - UART state = IDLE.
- Window latency: win_valid and data appear exactly 1 cycle after the accepted pix_stb.
- Back-to-back pix_stb every cycle is supported.
- pix_stb in the same cycle href falls: the pixel counts if href is high in that cycle.
- UART FSM: IDLE → START → DATA(8) → STOP → IDLE.
  - tx changes on the cycle after res_stb.
  - tx_busy deasserts after 10·BAUD_DIV cycles.
  - A new res_stb is accepted in that same cycle.
- rst mid-frame: all line state is discarded and the UART aborts with tx = 1 next cycle. RAM contents are don't-care.

## Test plan
- Reset → tx=1, tx_busy=0, win_valid=0. Pixels on lines 1–3 → no win_valid.
- Four 320-pixel lines with pixel = line·16 + (col mod 16): on line 4, column 5 gives top=0x05, mid=0x15, bot=0x25. win_valid pulses 320 times, each 1 cycle after pix_stb.
- Five lines → window rolls: line 5 column 200 gives top=0x18, mid=0x28, bot=0x38, confirming slot wrap w 3→0.
- vsync pulse after 2 lines, then 3 lines → no win_valid until the 4th line after vsync. An href pulse with 0 pixels does not advance w.
- 400-pixel line → columns 384–399 ignored. The next line's window for column 383 returns the stored pixel.
- res_data=0xA5, BAUD_DIV=1 → tx = 0,1,0,1,0,0,1,0,1,1 over 10 cycles. A second res_stb at cycle 5 is dropped. tx_busy is low at cycle 11.
